// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operation sequencer.
//   state_t      : sequencer states
//   OP_*         : operator codes presented on i_op / o_op
//   DISP_*       : display select codes for o_disp_sel
//   LED_*        : status LED patterns for o_state_led
//   disp_of/led_of : decode of a state into its display/LED outputs
package calc_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_RES  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] DISP_A    = 2'b00;
  localparam logic [1:0] DISP_B    = 2'b01;
  localparam logic [1:0] DISP_BUSY = 2'b10;
  localparam logic [1:0] DISP_RES  = 2'b11;

  localparam logic [3:0] LED_A    = 4'b0001;
  localparam logic [3:0] LED_B    = 4'b0010;
  localparam logic [3:0] LED_EXEC = 4'b0100;
  localparam logic [3:0] LED_RES  = 4'b1000;
  localparam logic [3:0] LED_ERR  = 4'b1111;

  function automatic logic [1:0] disp_of(state_t s);
    case (s)
      S_B:     return DISP_B;
      S_EXEC:  return DISP_BUSY;
      S_RES:   return DISP_RES;
      S_ERR:   return DISP_RES;
      default: return DISP_A;
    endcase
  endfunction

  function automatic logic [3:0] led_of(state_t s);
    case (s)
      S_B:     return LED_B;
      S_EXEC:  return LED_EXEC;
      S_RES:   return LED_RES;
      S_ERR:   return LED_ERR;
      default: return LED_A;
    endcase
  endfunction

endpackage

// File: rtl/calc_timeout_counter.sv
// Cycle counter guarding the wait for the arithmetic unit.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear to 0 (wins over i_en)
//   i_en           : count up by one per cycle
//   o_expired      : count has reached TIMEOUT_CYC-1
module calc_timeout_counter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      cnt <= '0;
    else if (i_clr)    cnt <= '0;
    // Hold at the terminal value; the sequencer leaves EXEC on expiry anyway.
    else if (i_en && cnt != LAST) cnt <= cnt + 1'b1;
  end

  assign o_expired = (cnt == LAST);

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: gathers operand A and B from switch entry,
// launches the arithmetic unit with a start/done handshake, captures the
// result or an error and drives display select and status LEDs.
//   i_clk, i_rst_n               : clock, async active-low reset
//   i_enter, i_clear             : 1-cycle button pulses
//   i_value, i_value_sign, i_op  : operand entry and operator
//   i_res, i_res_sign, i_done, i_err : arithmetic unit return path
//   o_start                      : 1-cycle launch pulse
//   o_s1*, o_s2*, o_op           : registered operands and operator
//   o_res, o_res_sign            : captured result
//   o_disp_sel, o_state_led, o_err, o_busy : status, decoded from next state
//
// state  | meaning
// S_A    | waiting for operand A entry
// S_B    | waiting for operand B and operator entry
// S_EXEC | arithmetic unit running, waiting for done or timeout
// S_RES  | result valid on display; enter chains it in as operand A
// S_ERR  | divide by zero, unit error or timeout; enter returns to S_A
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W      = 40,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enter,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_value_sign,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_res,
  input  logic              i_res_sign,
  input  logic              i_done,
  input  logic              i_err,
  output logic              o_start,
  output logic [DATA_W-1:0] o_s1,
  output logic              o_s1_sign,
  output logic [DATA_W-1:0] o_s2,
  output logic              o_s2_sign,
  output logic [1:0]        o_op,
  output logic [DATA_W-1:0] o_res,
  output logic              o_res_sign,
  output logic [1:0]        o_disp_sel,
  output logic [3:0]        o_state_led,
  output logic              o_err,
  output logic              o_busy
);

  state_t state, state_nxt;
  logic   expired;
  logic   load_a, load_b, chain, cap_res, clr_data, launch;

  calc_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_clear || state != S_EXEC),
    .i_en     (state == S_EXEC),
    .o_expired(expired)
  );

  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    chain     = 1'b0;
    cap_res   = 1'b0;
    clr_data  = 1'b0;
    launch    = 1'b0;
    if (i_clear) begin
      state_nxt = S_A;
      clr_data  = 1'b1;
    end else begin
      case (state)
        S_A: if (i_enter) begin
          load_a    = 1'b1;
          state_nxt = S_B;
        end
        S_B: if (i_enter) begin
          load_b = 1'b1;
          if (i_op == OP_DIV && i_value == '0) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_EXEC;
            launch    = 1'b1;
          end
        end
        S_EXEC: begin
          // A done arriving on the expiry cycle still counts.
          if (i_done) begin
            if (i_err) begin
              state_nxt = S_ERR;
            end else begin
              cap_res   = 1'b1;
              state_nxt = S_RES;
            end
          end else if (expired) begin
            state_nxt = S_ERR;
          end
        end
        S_RES: if (i_enter) begin
          chain     = 1'b1;
          state_nxt = S_B;
        end
        S_ERR: if (i_enter) begin
          clr_data  = 1'b1;
          state_nxt = S_A;
        end
        default: state_nxt = S_A;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_A;
      o_start     <= 1'b0;
      o_s1        <= '0;
      o_s1_sign   <= 1'b0;
      o_s2        <= '0;
      o_s2_sign   <= 1'b0;
      o_op        <= OP_ADD;
      o_res       <= '0;
      o_res_sign  <= 1'b0;
      o_disp_sel  <= DISP_A;
      o_state_led <= LED_A;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_start     <= launch;
      o_disp_sel  <= disp_of(state_nxt);
      o_state_led <= led_of(state_nxt);
      o_err       <= (state_nxt == S_ERR);
      o_busy      <= (state_nxt == S_EXEC);
      if (clr_data) begin
        o_s1       <= '0;
        o_s1_sign  <= 1'b0;
        o_s2       <= '0;
        o_s2_sign  <= 1'b0;
        o_op       <= OP_ADD;
        o_res      <= '0;
        o_res_sign <= 1'b0;
      end else begin
        if (load_a) begin
          o_s1      <= i_value;
          o_s1_sign <= i_value_sign;
        end
        if (chain) begin
          o_s1      <= o_res;
          o_s1_sign <= o_res_sign;
        end
        if (load_b) begin
          o_s2      <= i_value;
          o_s2_sign <= i_value_sign;
          o_op      <= i_op;
        end
        if (cap_res) begin
          o_res      <= i_res;
          o_res_sign <= i_res_sign;
        end
      end
    end
  end

endmodule
